// File: rtl/mac_operand_seq_if.sv
// Operand-stream and buffer-read bundle for mac_operand_seq.
//   master : sequencer side - drives read strobes/addresses and operand triples,
//            receives read data and op_ready.
//   slave  : environment side - memories return read data, MAC lane drives op_ready.
// Signals: fm_rd_en/fm_addr/fm_rdata, wt_rd_en/wt_addr/wt_rdata,
//          op_valid/op_ready/op_data/op_weight/op_bias/op_first/op_last.
interface mac_operand_seq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  fm_rd_en;
    logic [ADDR_WIDTH-1:0] fm_addr;
    logic [DATA_WIDTH-1:0] fm_rdata;
    logic                  wt_rd_en;
    logic [ADDR_WIDTH-1:0] wt_addr;
    logic [DATA_WIDTH-1:0] wt_rdata;
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_data;
    logic [DATA_WIDTH-1:0] op_weight;
    logic [DATA_WIDTH-1:0] op_bias;
    logic                  op_first;
    logic                  op_last;

    modport master (
        output fm_rd_en, fm_addr, wt_rd_en, wt_addr,
        output op_valid, op_data, op_weight, op_bias, op_first, op_last,
        input  fm_rdata, wt_rdata, op_ready
    );

    modport slave (
        input  fm_rd_en, fm_addr, wt_rd_en, wt_addr,
        input  op_valid, op_data, op_weight, op_bias, op_first, op_last,
        output fm_rdata, wt_rdata, op_ready
    );
endinterface

// File: rtl/mac_operand_seq.sv
// mac_operand_seq: walks one KERNEL_SIZE x KERNEL_SIZE window per start pulse,
// reads feature-map and weight buffers (1-cycle synchronous read) and streams
// (data, weight, bias) triples with first/last tags over a valid/ready handshake.
// Ports:
//   clk, rst (async, active-high)
//   start, win_base, wgt_base, bias_in : window request, latched when accepted in IDLE
//   busy, done                         : window in progress / one-cycle completion pulse
//   bus (mac_operand_seq_if.master)    : buffer read ports and operand stream
//   stall_cnt [15:0]                   : only when STALL_CNT_EN is defined; counts
//                                        op_valid & !op_ready cycles of the current window
// Optional feature macro: STALL_CNT_EN
module mac_operand_seq #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned IMG_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] win_base,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic                  busy,
    output logic                  done,
`ifdef STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    mac_operand_seq_if.master     bus
);

    localparam int unsigned CNT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [CNT_W-1:0]      K_LAST   = CNT_W'(KERNEL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] FM_PITCH = ADDR_WIDTH'(IMG_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] weight;
        logic                  first;
        logic                  last;
    } entry_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] fm_row_q, fm_row_d;
    logic [ADDR_WIDTH-1:0] fm_addr_q, fm_addr_d;
    logic [ADDR_WIDTH-1:0] wt_addr_q, wt_addr_d;
    logic [DATA_WIDTH-1:0] bias_q, bias_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_first_q, infl_first_d;
    logic                  infl_last_q, infl_last_d;
    entry_t                e0_q, e0_d;
    entry_t                e1_q, e1_d;
    logic                  v0_q, v0_d;
    logic                  v1_q, v1_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  pop_c;
    logic                  issue_c;
    logic                  accept_c;
    logic [1:0]            occ_c;
    entry_t                push_c;

    // Window sequencer: next state, address walk and read issue.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        fm_row_d  = fm_row_q;
        fm_addr_d = fm_addr_q;
        wt_addr_d = wt_addr_q;
        bias_d    = bias_q;
        accept_c  = 1'b0;
        issue_c   = 1'b0;
        pop_c     = v0_q & bus.op_ready;
        // Buffer slots committed after this cycle's pop; never exceeds 2.
        occ_c     = 2'(v0_q) + 2'(v1_q) + 2'(inflight_q) - 2'(pop_c);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_d   = S_RUN;
                    row_d     = '0;
                    col_d     = '0;
                    fm_row_d  = win_base;
                    fm_addr_d = win_base;
                    wt_addr_d = wgt_base;
                    bias_d    = bias_in;
                end
            end
            S_RUN: begin
                issue_c = (occ_c < 2'd2);
                if (issue_c) begin
                    // Kernel elements are contiguous in weight memory.
                    wt_addr_d = wt_addr_q + ADDR_WIDTH'(1);
                    if (col_q == K_LAST) begin
                        col_d     = '0;
                        fm_row_d  = fm_row_q + FM_PITCH;
                        fm_addr_d = fm_row_q + FM_PITCH;
                        if (row_q == K_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + CNT_W'(1);
                        end
                    end else begin
                        col_d     = col_q + CNT_W'(1);
                        fm_addr_d = fm_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop_c && e0_q.last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        inflight_d   = issue_c;
        infl_first_d = issue_c && (row_q == '0) && (col_q == '0);
        infl_last_d  = issue_c && (row_q == K_LAST) && (col_q == K_LAST);
    end

    // Two-entry shift buffer: head always in e0 so the operand outputs come straight from flops.
    always_comb begin
        e0_d   = e0_q;
        e1_d   = e1_q;
        v0_d   = v0_q;
        v1_d   = v1_q;
        push_c = '{data: bus.fm_rdata, weight: bus.wt_rdata,
                   first: infl_first_q, last: infl_last_q};
        if (pop_c) begin
            e0_d = v1_q ? e1_q : '0;
            v0_d = v1_q;
            e1_d = '0;
            v1_d = 1'b0;
        end
        if (inflight_q) begin
            if (!v0_d) begin
                e0_d = push_c;
                v0_d = 1'b1;
            end else begin
                e1_d = push_c;
                v1_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            fm_row_q     <= '0;
            fm_addr_q    <= '0;
            wt_addr_q    <= '0;
            bias_q       <= '0;
            inflight_q   <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            e0_q         <= '0;
            e1_q         <= '0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            fm_row_q     <= fm_row_d;
            fm_addr_q    <= fm_addr_d;
            wt_addr_q    <= wt_addr_d;
            bias_q       <= bias_d;
            inflight_q   <= inflight_d;
            infl_first_q <= infl_first_d;
            infl_last_q  <= infl_last_d;
            e0_q         <= e0_d;
            e1_q         <= e1_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of back-pressured cycles; restarts when a window is accepted.
    always_comb begin
        stall_d = stall_q;
        if (accept_c) begin
            stall_d = '0;
        end else if (v0_q && !bus.op_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.fm_rd_en  = issue_c;
    assign bus.wt_rd_en  = issue_c;
    assign bus.fm_addr   = fm_addr_q;
    assign bus.wt_addr   = wt_addr_q;
    assign bus.op_valid  = v0_q;
    assign bus.op_data   = e0_q.data;
    assign bus.op_weight = e0_q.weight;
    assign bus.op_bias   = bias_q;
    assign bus.op_first  = e0_q.first;
    assign bus.op_last   = e0_q.last;

endmodule
